// File: rtl/serial_insertion_sorter.sv
// ============================================================================
// Module   : serial_insertion_sorter
// Purpose  : Systolic insertion sorter; fills N cells ascending, drains smallest first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_insertion_sorter #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  input  logic                   out_ready,
  output logic [$clog2(N+1)-1:0] count
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_val [N];
  logic            r_occ [N];
  logic [CW-1:0]   r_count;

  logic            w_ins;
  logic            w_pop;
  logic            w_g      [N];
  logic            w_lo_g   [N];
  logic [W-1:0]    w_lo_val [N];
  logic            w_lo_occ [N];
  logic [W-1:0]    w_hi_val [N];
  logic            w_hi_occ [N];

  assign w_ins = (r_state == FILL) && in_valid;
  assign w_pop = (r_state == DRAIN) && out_ready;

  // Each cell sees its lower neighbour (for insert shift) and upper one (for pop).
  for (genvar i = 0; i < N; i++) begin : g_cell
    assign w_g[i] = !r_occ[i] || (in_data < r_val[i]);

    if (i == 0) begin : g_head
      assign w_lo_g[i]   = 1'b0;
      assign w_lo_val[i] = '0;
      assign w_lo_occ[i] = 1'b0;
    end else begin : g_body
      assign w_lo_g[i]   = w_g[i-1];
      assign w_lo_val[i] = r_val[i-1];
      assign w_lo_occ[i] = r_occ[i-1];
    end

    if (i == N - 1) begin : g_tail
      assign w_hi_val[i] = '0;
      assign w_hi_occ[i] = 1'b0;
    end else begin : g_mid
      assign w_hi_val[i] = r_val[i+1];
      assign w_hi_occ[i] = r_occ[i+1];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: begin
        if (w_ins && (r_count == C_LAST)) begin
          w_state_next = DRAIN;
        end else if (flush && (w_ins || (r_count != '0))) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && (r_count == C_ONE)) begin
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
      r_count <= '0;
      for (int i = 0; i < N; i++) begin
        r_val[i] <= '0;
        r_occ[i] <= 1'b0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_ins) begin
        r_count <= r_count + C_ONE;
        // Strict less-than keeps equal words in arrival order.
        for (int i = 0; i < N; i++) begin
          if (w_g[i]) begin
            if (!w_lo_g[i]) begin
              r_val[i] <= in_data;
              r_occ[i] <= 1'b1;
            end else begin
              r_val[i] <= w_lo_val[i];
              r_occ[i] <= w_lo_occ[i];
            end
          end
        end
      end else if (w_pop) begin
        r_count <= r_count - C_ONE;
        for (int i = 0; i < N; i++) begin
          r_val[i] <= w_hi_val[i];
          r_occ[i] <= w_hi_occ[i];
        end
      end
    end
  end

  assign in_ready  = (r_state == FILL);
  assign out_valid = (r_state == DRAIN);
  assign out_data  = r_val[0];
  assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_serial_insertion_sorter.sv
// Directed bench for serial_insertion_sorter with a sorted-value scoreboard.
`default_nettype none

module tb_serial_insertion_sorter;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         flush;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [3:0]   count;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] batch[$];
  logic [W-1:0] sb[$];

  serial_insertion_sorter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Insert one word this cycle; optional flush alongside it.
  task automatic feed(input logic [W-1:0] w, input logic fl);
    chk("in_ready_fill", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    flush    = fl;
    batch.push_back(w);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic close_batch();
    batch.sort();
    foreach (batch[i]) sb.push_back(batch[i]);
    batch.delete();
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 with junk input
  task automatic drain(input int mode);
    int cyc;
    logic r;
    cyc = 0;
    while (sb.size() > 0 && cyc < 64) begin
      r = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      out_ready = r;
      if (mode == 1) begin
        in_valid = 1'b1;
        in_data  = 8'd77;
      end
      chk("out_valid_drain", out_valid, 1);
      chk("in_ready_drain", in_ready, 0);
      chk("count_drain", count, sb.size());
      chk("out_data", out_data, sb[0]);
      if (r) void'(sb.pop_front());
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_done_in_time", (sb.size() == 0), 1);
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    chk("count_after", count, 0);
  endtask

  initial begin
    logic [W-1:0] v1 [8];
    logic [W-1:0] v2 [8];
    v1 = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
    v2 = '{8'd9, 8'd9, 8'd0, 8'd255, 8'd9, 8'd0, 8'd255, 8'd1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;
    tick();

    // Basic batch of eight with out_ready held high throughout
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) feed(v1[i], 1'b0);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_count", count, 8);
    close_batch();
    drain(0);

    // Duplicates and extremes
    for (int i = 0; i < 8; i++) feed(v2[i], 1'b0);
    close_batch();
    chk("dup_head", sb[0], 0);
    drain(0);

    // Early flush on the third word
    feed(8'd40, 1'b0);
    feed(8'd10, 1'b0);
    feed(8'd30, 1'b1);
    chk("flush_out_valid", out_valid, 1);
    chk("flush_count", count, 3);
    close_batch();
    drain(0);

    // Backpressure with ignored input traffic
    for (int i = 0; i < 8; i++) feed(W'($urandom_range(0, 255)), 1'b0);
    close_batch();
    drain(1);

    // Reset in the middle of a drain
    for (int i = 0; i < 8; i++) feed(W'($urandom_range(0, 255)), 1'b0);
    close_batch();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst_data", out_data, sb[0]);
      void'(sb.pop_front());
      tick();
    end
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    sb.delete();
    tick();
    for (int i = 0; i < 8; i++) feed(W'($urandom_range(0, 255)), 1'b0);
    close_batch();
    drain(0);

    // Flush while empty is a no-op; then boundary values 255, 0
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("empty_flush_in_ready", in_ready, 1);
    chk("empty_flush_out_valid", out_valid, 0);
    chk("empty_flush_count", count, 0);
    feed(8'd255, 1'b0);
    feed(8'd0, 1'b0);
    chk("pair_count", count, 2);
    chk("pair_still_fill", in_ready, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pair_out_valid", out_valid, 1);
    close_batch();
    drain(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
